// File: rtl/ctrl_axis_arbiter.sv
// Packet-atomic round-robin arbiter merging two control AXI-Stream sources onto the stage control chain.
// Define CTRL_ARB_GAP_EN to insert GAP_CYCLES idle cycles after every packet.
//   state | meaning
//   IDLE  | no grant held, arbitrating between requesters
//   XFER  | granted source forwards beats until its tlast is accepted
//   GAP   | post-packet idle gap for table commit (CTRL_ARB_GAP_EN only)
module ctrl_axis_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int GAP_CYCLES           = 4
) (
    input  logic                                 axis_clk,
    input  logic                                 axis_rst,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s0_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s0_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s0_axis_tkeep,
    input  logic                                 s0_axis_tvalid,
    input  logic                                 s0_axis_tlast,
    output logic                                 s0_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s1_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s1_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s1_axis_tkeep,
    input  logic                                 s1_axis_tvalid,
    input  logic                                 s1_axis_tlast,
    output logic                                 s1_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
    output logic                                 c_m_axis_tvalid,
    output logic                                 c_m_axis_tlast,

    output logic                                 busy,
    output logic [15:0]                          pkt_cnt_0,
    output logic [15:0]                          pkt_cnt_1
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_gap_range
        $error("ctrl_axis_arbiter: GAP_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1
`ifdef CTRL_ARB_GAP_EN
        ,
        ST_GAP  = 2'd2
`endif
    } state_t;

    state_t state, state_nxt;
    logic   grant, grant_nxt;
    logic   rr, rr_nxt;
    logic   sel_valid, sel_last;
    logic   beat_acc, last_acc;

`ifdef CTRL_ARB_GAP_EN
    logic [7:0] gap_cnt;
`endif

    // Readies depend on registered state only, never on tvalid.
    assign s0_axis_tready = (state == ST_XFER) && !grant;
    assign s1_axis_tready = (state == ST_XFER) &&  grant;
    assign busy           = (state != ST_IDLE);

    assign sel_valid = grant ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_last  = grant ? s1_axis_tlast  : s0_axis_tlast;
    assign beat_acc  = (state == ST_XFER) && sel_valid;
    assign last_acc  = beat_acc && sel_last;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr;
        case (state)
            ST_IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid) begin
                    state_nxt = ST_XFER;
                    grant_nxt = rr;
                end else if (s0_axis_tvalid) begin
                    state_nxt = ST_XFER;
                    grant_nxt = 1'b0;
                end else if (s1_axis_tvalid) begin
                    state_nxt = ST_XFER;
                    grant_nxt = 1'b1;
                end
            end
            ST_XFER: begin
                if (last_acc) begin
                    rr_nxt = ~grant;
`ifdef CTRL_ARB_GAP_EN
                    state_nxt = ST_GAP;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef CTRL_ARB_GAP_EN
            ST_GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state           <= ST_IDLE;
            grant           <= 1'b0;
            rr              <= 1'b0;
            pkt_cnt_0       <= '0;
            pkt_cnt_1       <= '0;
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end else begin
            state           <= state_nxt;
            grant           <= grant_nxt;
            rr              <= rr_nxt;
            c_m_axis_tvalid <= beat_acc;
            c_m_axis_tlast  <= last_acc;
            // Payload holds its last value across bubbles.
            if (beat_acc) begin
                c_m_axis_tdata <= grant ? s1_axis_tdata : s0_axis_tdata;
                c_m_axis_tuser <= grant ? s1_axis_tuser : s0_axis_tuser;
                c_m_axis_tkeep <= grant ? s1_axis_tkeep : s0_axis_tkeep;
            end
            if (last_acc) begin
                if (grant) begin
                    pkt_cnt_1 <= pkt_cnt_1 + 16'd1;
                end else begin
                    pkt_cnt_0 <= pkt_cnt_0 + 16'd1;
                end
            end
        end
    end

`ifdef CTRL_ARB_GAP_EN
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            gap_cnt <= '0;
        end else if (last_acc) begin
            gap_cnt <= 8'(GAP_CYCLES - 1);
        end else if ((state == ST_GAP) && (gap_cnt != 8'd0)) begin
            gap_cnt <= gap_cnt - 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_axis_arbiter.sv
// Directed bench for ctrl_axis_arbiter with a beat scoreboard on the merged output.
// Gap-timing expectations follow CTRL_ARB_GAP_EN when the bench is built with it.
module tb_ctrl_axis_arbiter;

    localparam int DW  = 32;
    localparam int UW  = 16;
    localparam int KW  = DW / 8;
    localparam int GAP = 4;
`ifdef CTRL_ARB_GAP_EN
    localparam bit GAP_EN = 1'b1;
    localparam int RISE   = GAP + 2;
`else
    localparam bit GAP_EN = 1'b0;
    localparam int RISE   = 2;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          axis_clk;
    logic          axis_rst;
    logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, c_m_axis_tdata;
    logic [UW-1:0] s0_axis_tuser, s1_axis_tuser, c_m_axis_tuser;
    logic [KW-1:0] s0_axis_tkeep, s1_axis_tkeep, c_m_axis_tkeep;
    logic          s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
    logic          s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
    logic          c_m_axis_tvalid, c_m_axis_tlast;
    logic          busy;
    logic [15:0]   pkt_cnt_0, pkt_cnt_1;

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];

    ctrl_axis_arbiter #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .GAP_CYCLES          (GAP)
    ) dut (
        .axis_clk       (axis_clk),
        .axis_rst       (axis_rst),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tuser  (s0_axis_tuser),
        .s0_axis_tkeep  (s0_axis_tkeep),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tready (s0_axis_tready),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tuser  (s1_axis_tuser),
        .s1_axis_tkeep  (s1_axis_tkeep),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tready (s1_axis_tready),
        .c_m_axis_tdata (c_m_axis_tdata),
        .c_m_axis_tuser (c_m_axis_tuser),
        .c_m_axis_tkeep (c_m_axis_tkeep),
        .c_m_axis_tvalid(c_m_axis_tvalid),
        .c_m_axis_tlast (c_m_axis_tlast),
        .busy           (busy),
        .pkt_cnt_0      (pkt_cnt_0),
        .pkt_cnt_1      (pkt_cnt_1)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int src, input int pkt, input int idx, input bit last);
        beat_t b;
        b.data = {4'(src), 20'(pkt), 8'(idx)};
        b.user = {8'(idx), 8'(pkt) ^ 8'hA5};
        b.keep = 4'(idx + src + 1);
        b.last = last;
        return b;
    endfunction

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic drive(input int src, input logic vld, input beat_t b);
        if (src == 0) begin
            s0_axis_tvalid = vld;
            s0_axis_tdata  = b.data;
            s0_axis_tuser  = b.user;
            s0_axis_tkeep  = b.keep;
            s0_axis_tlast  = b.last;
        end else begin
            s1_axis_tvalid = vld;
            s1_axis_tdata  = b.data;
            s1_axis_tuser  = b.user;
            s1_axis_tkeep  = b.keep;
            s1_axis_tlast  = b.last;
        end
    endtask

    function automatic logic rdy(input int src);
        return (src == 0) ? s0_axis_tready : s1_axis_tready;
    endfunction

    task automatic push_pkt(input int src, input int pkt, input int nb);
        for (int i = 0; i < nb; i++) exp_q.push_back(mk_beat(src, pkt, i, i == nb - 1));
    endtask

    // Presents each beat until the arbiter accepts it, with a bounded wait.
    task automatic send_pkt(input int src, input int pkt, input int nb);
        int n;
        for (int i = 0; i < nb; i++) begin
            drive(src, 1'b1, mk_beat(src, pkt, i, i == nb - 1));
            n = 0;
            while (rdy(src) !== 1'b1 && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) begin
                check($sformatf("ready_timeout_s%0d", src), 64'(rdy(src)), 64'd1);
                drive(src, 1'b0, mk_beat(src, pkt, i, 1'b0));
                return;
            end
            tick();
        end
        drive(src, 1'b0, mk_beat(src, pkt, nb - 1, 1'b1));
    endtask

    always @(negedge axis_clk) begin
        beat_t ob;
        beat_t e;
        if (c_m_axis_tvalid === 1'b1) begin
            ob = {c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast};
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL sb_unexpected_beat observed=0x%0h expected=none", ob);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_beat", 64'(ob), 64'(e));
            end
        end
    end

    initial begin
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        axis_rst = 1'b1;
        tick();
        tick();
        check("rst_outputs", 64'({c_m_axis_tvalid, c_m_axis_tlast, s0_axis_tready, s1_axis_tready, busy}), 64'd0);
        check("rst_counters", 64'({pkt_cnt_0, pkt_cnt_1}), 64'd0);
        axis_rst = 1'b0;

        // Single source, 3-beat packet, tvalid rising at t0
        push_pkt(0, 0, 3);
        drive(0, 1'b1, mk_beat(0, 0, 0, 1'b0));
        check("t1_rdy_t0", 64'(s0_axis_tready), 64'd0);
        tick();
        check("t1_rdy_t1", 64'(s0_axis_tready), 64'd1);
        check("t1_vld_t1", 64'(c_m_axis_tvalid), 64'd0);
        tick();
        check("t1_rdy_t2", 64'(s0_axis_tready), 64'd1);
        check("t1_vld_last_t2", 64'({c_m_axis_tvalid, c_m_axis_tlast}), 64'b10);
        drive(0, 1'b1, mk_beat(0, 0, 1, 1'b0));
        tick();
        check("t1_rdy_t3", 64'(s0_axis_tready), 64'd1);
        check("t1_vld_last_t3", 64'({c_m_axis_tvalid, c_m_axis_tlast}), 64'b10);
        drive(0, 1'b1, mk_beat(0, 0, 2, 1'b1));
        tick();
        check("t1_rdy_t4", 64'(s0_axis_tready), 64'd0);
        check("t1_vld_last_t4", 64'({c_m_axis_tvalid, c_m_axis_tlast}), 64'b11);
        drive(0, 1'b0, mk_beat(0, 0, 2, 1'b1));
        tick();
        check("t1_vld_t5", 64'(c_m_axis_tvalid), 64'd0);
        check("t1_counts", 64'({pkt_cnt_0, pkt_cnt_1}), 64'({16'd1, 16'd0}));

        // Grant lock across a 3-cycle tvalid gap, then post-packet timing to s1
        push_pkt(0, 1, 3);
        push_pkt(1, 0, 1);
        drive(0, 1'b1, mk_beat(0, 1, 0, 1'b0));
        tick();
        check("lk_s0_rdy_t1", 64'(s0_axis_tready), 64'd1);
        drive(1, 1'b1, mk_beat(1, 0, 0, 1'b1));
        tick();
        check("lk_s1_rdy_t2", 64'(s1_axis_tready), 64'd0);
        drive(0, 1'b1, mk_beat(0, 1, 1, 1'b0));
        tick();
        check("lk_s1_rdy_t3", 64'(s1_axis_tready), 64'd0);
        check("lk_vld_t3", 64'(c_m_axis_tvalid), 64'd1);
        drive(0, 1'b0, mk_beat(0, 1, 1, 1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("lk_bubble_%0d", i), 64'({c_m_axis_tvalid, s0_axis_tready, s1_axis_tready, busy}), 64'b0101);
        end
        drive(0, 1'b1, mk_beat(0, 1, 2, 1'b1));
        for (int k = 1; k <= RISE; k++) begin
            tick();
            if (k == 1) drive(0, 1'b0, mk_beat(0, 1, 2, 1'b1));
            check($sformatf("gap_s1_rdy_t+%0d", k), 64'(s1_axis_tready), 64'(k == RISE));
            check($sformatf("gap_busy_t+%0d", k), 64'(busy), 64'((k == RISE) || (GAP_EN && k <= GAP)));
            check($sformatf("gap_vld_t+%0d", k), 64'({c_m_axis_tvalid, c_m_axis_tlast}), 64'((k == 1) ? 2'b11 : 2'b00));
        end
        tick();
        drive(1, 1'b0, mk_beat(1, 0, 0, 1'b1));
        check("lk_s1_out", 64'({c_m_axis_tvalid, c_m_axis_tlast}), 64'b11);
        check("lk_counts", 64'({pkt_cnt_0, pkt_cnt_1}), 64'({16'd2, 16'd1}));
        repeat (GAP + 2) tick();
        check("lk_idle", 64'(busy), 64'd0);

        // Contention from reset: both sources stream 2-beat packets continuously
        axis_rst = 1'b1;
        tick();
        axis_rst = 1'b0;
        push_pkt(0, 10, 2);
        push_pkt(1, 10, 2);
        push_pkt(0, 11, 2);
        push_pkt(1, 11, 2);
        fork
            begin
                send_pkt(0, 10, 2);
                send_pkt(0, 11, 2);
            end
            begin
                send_pkt(1, 10, 2);
                send_pkt(1, 11, 2);
            end
        join
        repeat (GAP + 3) tick();
        check("ct_counts", 64'({pkt_cnt_0, pkt_cnt_1}), 64'({16'd2, 16'd2}));
        check("ct_drained", 64'(exp_q.size()), 64'd0);

        // Counter wrap on s1, preloaded near the top of its range
        axis_rst = 1'b1;
        tick();
        axis_rst = 1'b0;
        force dut.pkt_cnt_1 = 16'hFFFD;
        tick();
        release dut.pkt_cnt_1;
        tick();
        check("wr_preload", 64'(pkt_cnt_1), 64'h FFFD);
        for (int p = 0; p < 3; p++) begin
            push_pkt(1, 20 + p, 1);
            send_pkt(1, 20 + p, 1);
            check($sformatf("wr_cnt1_%0d", p), 64'(pkt_cnt_1), 64'(16'(32'hFFFE + p)));
        end
        check("wr_cnt0", 64'(pkt_cnt_0), 64'd0);
        push_pkt(1, 23, 1);
        send_pkt(1, 23, 1);
        push_pkt(0, 23, 1);
        send_pkt(0, 23, 1);
        repeat (GAP + 2) tick();
        check("wr_counts_after", 64'({pkt_cnt_0, pkt_cnt_1}), 64'({16'd1, 16'd1}));

        // Reset on beat 2 of a 4-beat s0 packet, then simultaneous restart
        push_pkt(0, 30, 1);
        exp_q[exp_q.size() - 1].last = 1'b0;
        drive(0, 1'b1, mk_beat(0, 30, 0, 1'b0));
        tick();
        tick();
        drive(0, 1'b1, mk_beat(0, 30, 1, 1'b0));
        axis_rst = 1'b1;
        tick();
        check("mr_ctrl_zero", 64'({c_m_axis_tvalid, c_m_axis_tlast, s0_axis_tready, s1_axis_tready, busy}), 64'd0);
        check("mr_payload_zero", 64'({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep}), 64'd0);
        check("mr_counters_zero", 64'({pkt_cnt_0, pkt_cnt_1}), 64'd0);
        axis_rst = 1'b0;
        push_pkt(0, 31, 1);
        push_pkt(1, 31, 1);
        fork
            send_pkt(0, 31, 1);
            send_pkt(1, 31, 1);
        join
        repeat (GAP + 3) tick();
        check("mr_counts", 64'({pkt_cnt_0, pkt_cnt_1}), 64'({16'd1, 16'd1}));
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
